slave_mem_bank: RTL and testbench

//  Parametrised crossbar slave: word-addressed register/memory bank behind the req/ack/resp handshake.

---
 rtl/slave_pkg.sv | 15 +
 rtl/slave_mem_bank_array.sv | 23 ++
 rtl/slave_mem_bank.sv | 134 +++++++++++++
 tb/tb_slave_mem_bank.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/slave_pkg.sv
// Shared types and constants for the crossbar slave memory bank.
package slave_pkg;

    localparam int   ID_W      = 4;
    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_WAIT,
        S_RESP
    } state_e;

endpackage

// File: rtl/slave_mem_bank_array.sv
// Word storage for slave_mem_bank: synchronous write, asynchronous read, no reset.
module slave_mem_array #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] idx_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/slave_mem_bank.sv
// Crossbar slave: word-addressed bank behind req/ack/resp with WAIT_CYCLES response delay.
// Define SLAVE_MEM_BANK_ERR_EN to reject addresses whose ID field differs from SLAVE_ID.
module slave_mem_bank
    import slave_pkg::*;
#(
    parameter int              DATA_W      = 32,
    parameter int              ADDR_W      = 32,
    parameter int              DEPTH_LOG2  = 4,
    parameter logic [ID_W-1:0] SLAVE_ID    = 4'h1,
    parameter int              WAIT_CYCLES = 0
) (
    input  logic              slave_clk,
    input  logic              slave_rst_in,
    input  logic              slave_req,
    input  logic              slave_cmd,
    input  logic [ADDR_W-1:0] slave_addr,
    input  logic [DATA_W-1:0] slave_wdata,
    output logic              slave_ack,
    output logic              slave_resp,
    output logic [DATA_W-1:0] slave_rdata,
    output logic              slave_busy,
    output logic              slave_err
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    cmd_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W-1:0]       rdata_q;
    logic [DATA_W-1:0]       mem_rdata;
    logic                    hit;
    logic                    enter_resp;
    logic                    mem_we;
    logic                    addr_unused;

    // Only the index (and optionally the ID field) of the address is decoded.
    assign addr_unused = ^slave_addr;

    always_ff @(posedge slave_clk) begin
        if (slave_rst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (slave_req) state_d = S_ACK;
            S_ACK:   state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt_q == CNT_W'(1)) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        slave_ack  = (state_q == S_ACK);
        slave_resp = (state_q == S_RESP);
        slave_busy = (state_q != S_IDLE);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_ACK) begin
            cnt_d = CNT_W'(WAIT_CYCLES);
        end else if (state_q == S_WAIT) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Reset on the commit edge drops the pending write.
    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP) && !slave_rst_in;
    assign mem_we     = enter_resp && (cmd_q == CMD_WRITE) && hit;

    always_ff @(posedge slave_clk) begin
        if (slave_rst_in) begin
            cnt_q   <= '0;
            cmd_q   <= CMD_READ;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            rdata_q <= (enter_resp && (cmd_q == CMD_READ) && hit) ? mem_rdata : '0;
            if (state_q == S_IDLE && slave_req) begin
                cmd_q   <= slave_cmd;
                idx_q   <= slave_addr[DEPTH_LOG2-1:0];
                wdata_q <= slave_wdata;
            end
        end
    end

`ifdef SLAVE_MEM_BANK_ERR_EN
    logic hit_q;
    logic err_q;

    always_ff @(posedge slave_clk) begin
        if (slave_rst_in) begin
            hit_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            err_q <= enter_resp && !hit_q;
            if (state_q == S_IDLE && slave_req) begin
                hit_q <= (slave_addr[ADDR_W-1 -: ID_W] == SLAVE_ID);
            end
        end
    end

    assign hit       = hit_q;
    assign slave_err = err_q;
`else
    assign hit       = 1'b1;
    assign slave_err = 1'b0;
`endif

    assign slave_rdata = rdata_q;

    slave_mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk_i   (slave_clk),
        .we_i    (mem_we),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_slave_mem_bank.sv
// Directed bench: instance 0 has no wait states, instance 1 has WAIT_CYCLES=3.
module tb_slave_mem_bank;

    localparam int W0 = 0;
    localparam int W1 = 3;
    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

    logic        clk;
    logic        rst   [2];
    logic        req   [2];
    logic        cmd   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ack   [2];
    logic        resp  [2];
    logic [31:0] rdata [2];
    logic        busy  [2];
    logic        err   [2];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    slave_mem_bank #(.WAIT_CYCLES(W0)) u_dut0 (
        .slave_clk (clk), .slave_rst_in (rst[0]), .slave_req (req[0]),
        .slave_cmd (cmd[0]), .slave_addr (addr[0]), .slave_wdata (wdata[0]),
        .slave_ack (ack[0]), .slave_resp (resp[0]), .slave_rdata (rdata[0]),
        .slave_busy (busy[0]), .slave_err (err[0])
    );

    slave_mem_bank #(.WAIT_CYCLES(W1)) u_dut1 (
        .slave_clk (clk), .slave_rst_in (rst[1]), .slave_req (req[1]),
        .slave_cmd (cmd[1]), .slave_addr (addr[1]), .slave_wdata (wdata[1]),
        .slave_ack (ack[1]), .slave_resp (resp[1]), .slave_rdata (rdata[1]),
        .slave_busy (busy[1]), .slave_err (err[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; ack expected at +1, resp at +2+wait.
    task automatic txn(input int d, input string tag, input logic c, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        int nw;
        nw = (d == 0) ? W0 : W1;
        req[d] = 1'b1; cmd[d] = c; addr[d] = a; wdata[d] = wd;
        tick();
        chk({tag, "_ack"}, {61'd0, ack[d], busy[d], resp[d]}, 64'b110);
        req[d] = 1'b0; cmd[d] = ~c; addr[d] = 32'hFFFF_FFFF; wdata[d] = 32'hDEAD_BEEF;
        for (int i = 0; i < nw; i++) begin
            tick();
            chk({tag, "_wait"}, {61'd0, ack[d], busy[d], resp[d]}, 64'b010);
        end
        tick();
        chk({tag, "_resp"}, {60'd0, ack[d], busy[d], resp[d], err[d]}, {60'd0, 3'b011, exp_err});
        chk({tag, "_rdata"}, {32'd0, rdata[d]}, {32'd0, exp_rd});
        tick();
        chk({tag, "_idle"}, {28'd0, ack[d], busy[d], resp[d], err[d], rdata[d]}, 64'd0);
    endtask

    initial begin
        logic saw_resp;
        logic [31:0] vals [3];
        vals[0] = 32'h5050_0005; vals[1] = 32'h6060_0006; vals[2] = 32'h7070_0007;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; cmd[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
        end
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            chk("reset_out", {28'd0, ack[d], busy[d], resp[d], err[d], rdata[d]}, 64'd0);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        tick();

        txn(0, "w1111", WR, 32'h1000_0001, 32'h1111, 32'h0, 1'b0);
        txn(0, "r1111", RD, 32'h1000_0001, 32'h0, 32'h1111, 1'b0);
        txn(0, "w2222", WR, 32'h1000_0002, 32'h2222, 32'h0, 1'b0);
        txn(0, "w3333", WR, 32'h1000_0004, 32'h3333, 32'h0, 1'b0);
        txn(0, "r2222", RD, 32'h1000_0002, 32'h0, 32'h2222, 1'b0);
        txn(0, "r3333", RD, 32'h1000_0004, 32'h0, 32'h3333, 1'b0);

        txn(1, "w9999", WR, 32'h1000_0009, 32'h9999, 32'h0, 1'b0);
        txn(1, "r9999", RD, 32'h1000_0009, 32'h0, 32'h9999, 1'b0);

        // req held high: three writes, acks three cycles apart
        req[0] = 1'b1; cmd[0] = WR; addr[0] = 32'h1000_0005; wdata[0] = vals[0];
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b2b_ack", {62'd0, ack[0], resp[0]}, 64'b10);
            if (i < 2) begin
                addr[0] = 32'h1000_0006 + 32'(i); wdata[0] = vals[i+1];
            end else begin
                req[0] = 1'b0;
            end
            tick();
            chk("b2b_resp", {62'd0, ack[0], resp[0]}, 64'b01);
            tick();
            chk("b2b_gap", {62'd0, ack[0], resp[0]}, 64'b00);
        end
        txn(0, "b2b_r5", RD, 32'h1000_0005, 32'h0, vals[0], 1'b0);
        txn(0, "b2b_r6", RD, 32'h1000_0006, 32'h0, vals[1], 1'b0);
        txn(0, "b2b_r7", RD, 32'h1000_0007, 32'h0, vals[2], 1'b0);

        // reset mid-WAIT drops the write
        txn(1, "wAAA", WR, 32'h1000_0003, 32'h0AAA, 32'h0, 1'b0);
        req[1] = 1'b1; cmd[1] = WR; addr[1] = 32'h1000_0003; wdata[1] = 32'h77;
        tick();
        chk("rst_ack", {63'd0, ack[1]}, 64'd1);
        req[1] = 1'b0;
        tick();
        chk("rst_inwait", {61'd0, ack[1], busy[1], resp[1]}, 64'b010);
        rst[1] = 1'b1;
        tick();
        chk("rst_out", {28'd0, ack[1], busy[1], resp[1], err[1], rdata[1]}, 64'd0);
        tick();
        rst[1] = 1'b0;
        saw_resp = 1'b0;
        repeat (6) begin
            tick();
            saw_resp = saw_resp | resp[1] | busy[1];
        end
        chk("rst_noresp", {63'd0, saw_resp}, 64'd0);
        txn(1, "rst_rd", RD, 32'h1000_0003, 32'h0, 32'h0AAA, 1'b0);

`ifdef SLAVE_MEM_BANK_ERR_EN
        txn(0, "err_wr", WR, 32'h2000_0001, 32'h5555, 32'h0, 1'b1);
        txn(0, "err_keep", RD, 32'h1000_0001, 32'h0, 32'h1111, 1'b0);
        txn(0, "alias", RD, 32'h1000_0011, 32'h0, 32'h1111, 1'b0);
        txn(0, "err_rd", RD, 32'h2000_0001, 32'h0, 32'h0, 1'b1);
`else
        txn(0, "alias", RD, 32'h1000_0011, 32'h0, 32'h1111, 1'b0);
        txn(0, "noid_wr", WR, 32'h2000_0001, 32'h5555, 32'h0, 1'b0);
        txn(0, "noid_rd", RD, 32'h1000_0011, 32'h0, 32'h5555, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
